// File: rtl/time_entry_if.sv
// Signal bundle between the keypad/timer environment (master) and the
// time_entry writer (slave).
interface time_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       tick_1s;
    logic       timer_zero;
    logic [3:0] first_sec;
    logic [3:0] second_sec;
    logic [3:0] first_min;
    logic [3:0] second_min;
    logic       load_time_en;
    logic       clear_input;
    logic [2:0] digit_count;
    logic       busy;
    logic       entry_error;
    logic       done;

    modport master (
        output key_valid, key_code, tick_1s, timer_zero,
        input  first_sec, second_sec, first_min, second_min,
               load_time_en, clear_input, digit_count, busy, entry_error, done
    );

    modport slave (
        input  key_valid, key_code, tick_1s, timer_zero,
        output first_sec, second_sec, first_min, second_min,
               load_time_en, clear_input, digit_count, busy, entry_error, done
    );
endinterface

// File: rtl/time_entry.sv
// Keypad-side writer for the countdown timer: shifts BCD digits in from the
// right, validates them on START and holds load/clear requests until the
// timer's 1 s tick confirms they were sampled.
module time_entry #(
    parameter int MAX_DIGITS   = 4,
    parameter int MAX_SEC_TENS = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    time_entry_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, CLR} state_t;

    typedef struct packed {
        logic [3:0] second_min;
        logic [3:0] first_min;
        logic [3:0] second_sec;
        logic [3:0] first_sec;
    } digits_t;

    localparam logic [3:0] KEY_CLEAR    = 4'd10;
    localparam logic [3:0] KEY_START    = 4'd11;
    localparam logic [2:0] MAX_CNT      = 3'(MAX_DIGITS);
    localparam logic [3:0] SEC_TENS_LIM = 4'(MAX_SEC_TENS);

    state_t     state_q, state_d;
    digits_t    digits_q, digits_d;
    logic [2:0] count_q, count_d;
    logic       error_q, error_d;
    logic       done_q, done_d;
    logic       load_q, clear_q, busy_q;
    // High from the second LOAD cycle on: a tick coinciding with the first
    // LOAD cycle arrives before the timer could have seen the request.
    logic       armed_q;

    logic is_digit, is_clear, is_start, all_zero;

    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign is_start = bus.key_valid && (bus.key_code == KEY_START);
    assign all_zero = (digits_q == '0);

    // Next-state, digit shift register and one-cycle pulse decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        error_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, ENTRY: begin
                if (is_digit) begin
                    if (count_q < MAX_CNT) begin
                        digits_d = {digits_q.first_min, digits_q.second_sec,
                                    digits_q.first_sec, bus.key_code};
                        count_d  = count_q + 3'd1;
                    end
                    state_d = ENTRY;
                end else if (is_clear) begin
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = IDLE;
                end else if (is_start && !all_zero) begin
                    if (digits_q.second_sec > SEC_TENS_LIM) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.tick_1s && armed_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // CLEAR outranks a simultaneous natural finish.
                if (is_clear) begin
                    state_d = CLR;
                end else if (bus.tick_1s && bus.timer_zero) begin
                    done_d   = 1'b1;
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = IDLE;
                end
            end
            CLR: begin
                if (bus.tick_1s) begin
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            digits_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            error_q  <= error_d;
            done_q   <= done_d;
            load_q   <= (state_d == LOAD);
            clear_q  <= (state_d == CLR);
            busy_q   <= (state_d == LOAD) || (state_d == RUN) || (state_d == CLR);
            armed_q  <= (state_q == LOAD);
        end
    end

    assign bus.second_min   = digits_q.second_min;
    assign bus.first_min    = digits_q.first_min;
    assign bus.second_sec   = digits_q.second_sec;
    assign bus.first_sec    = digits_q.first_sec;
    assign bus.digit_count  = count_q;
    assign bus.load_time_en = load_q;
    assign bus.clear_input  = clear_q;
    assign bus.busy         = busy_q;
    assign bus.entry_error  = error_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed vector table, hand-written
// multi-cycle sequences, then random keys/ticks against a decimal-value model.
module tb_time_entry;
    logic clk = 1'b0;
    logic reset_n;

    time_entry_if bus();

    time_entry #(.MAX_DIGITS(4), .MAX_SEC_TENS(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the entry as a decimal number plus a coarse phase.
    typedef enum int {M_WAIT, M_LOADING, M_COOK, M_CLEARING} mode_t;
    mode_t m_mode;
    int    m_val;
    int    m_cnt;
    int    m_age;
    bit    m_err;
    bit    m_done;

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic       tk;
        logic       tz;
        logic [15:0] dig;
        logic [2:0] cnt;
        logic       ld;
        logic       cl;
        logic       bz;
        logic       er;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] dut_out();
        return {bus.second_min, bus.first_min, bus.second_sec, bus.first_sec,
                bus.digit_count, bus.load_time_en, bus.clear_input, bus.busy,
                bus.entry_error, bus.done};
    endfunction

    function automatic logic [23:0] model_out();
        logic [15:0] d;
        d = {4'((m_val / 1000) % 10), 4'((m_val / 100) % 10),
             4'((m_val / 10) % 10), 4'(m_val % 10)};
        return {d, 3'(m_cnt), m_mode == M_LOADING, m_mode == M_CLEARING,
                m_mode != M_WAIT, m_err, m_done};
    endfunction

    function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic tk,
                                input logic tz, input logic [15:0] dig, input logic [2:0] cnt,
                                input logic ld, input logic bz, input logic er, input logic dn);
        vec_t v;
        v.kv = kv; v.kc = kc; v.tk = tk; v.tz = tz;
        v.dig = dig; v.cnt = cnt; v.ld = ld; v.cl = 1'b0; v.bz = bz; v.er = er; v.dn = dn;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_WAIT; m_val = 0; m_cnt = 0; m_age = 0; m_err = 0; m_done = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc, input logic tk, input logic tz);
        m_err  = 0;
        m_done = 0;
        case (m_mode)
            M_WAIT: begin
                if (kv && kc <= 9) begin
                    if (m_cnt < 4) begin
                        m_val = m_val * 10 + int'(kc);
                        m_cnt++;
                    end
                end else if (kv && kc == 10) begin
                    m_val = 0; m_cnt = 0;
                end else if (kv && kc == 11 && m_val != 0) begin
                    if ((m_val / 10) % 10 > 5) m_err = 1;
                    else begin
                        m_mode = M_LOADING;
                        m_age  = 0;
                    end
                end
            end
            M_LOADING: begin
                if (tk && m_age >= 1) m_mode = M_COOK;
                m_age++;
            end
            M_COOK: begin
                if (kv && kc == 10) m_mode = M_CLEARING;
                else if (tk && tz) begin
                    m_done = 1; m_val = 0; m_cnt = 0; m_mode = M_WAIT;
                end
            end
            M_CLEARING: begin
                if (tk) begin
                    m_val = 0; m_cnt = 0; m_mode = M_WAIT;
                end
            end
            default: m_mode = M_WAIT;
        endcase
    endtask

    // One clock cycle with the given strobes; outputs are stable at return.
    task automatic cycle(input logic kv, input logic [3:0] kc, input logic tk, input logic tz);
        bus.key_valid  = kv;
        bus.key_code   = kc;
        bus.tick_1s    = tk;
        bus.timer_zero = tz;
        model_step(kv, kc, tk, tz);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.tick_1s   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.key_valid = 1'b0; bus.key_code = 4'd0; bus.tick_1s = 1'b0; bus.timer_zero = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        // Directed vectors: inputs for one cycle, outputs expected after it.
        //          kv  kc     tk tz  digits    cnt ld bz er dn
        tbl.push_back(mk(1, 4'd1,  0, 0, 16'h0001, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd2,  0, 0, 16'h0012, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd3,  0, 0, 16'h0123, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd0,  0, 0, 16'h1230, 4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd11, 0, 0, 16'h1230, 4, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'd0,  1, 0, 16'h1230, 4, 1, 1, 0, 0)); // tick in first LOAD cycle ignored
        tbl.push_back(mk(0, 4'd0,  0, 0, 16'h1230, 4, 1, 1, 0, 0));
        tbl.push_back(mk(1, 4'd10, 0, 0, 16'h1230, 4, 1, 1, 0, 0)); // keys ignored in LOAD
        tbl.push_back(mk(0, 4'd0,  0, 0, 16'h1230, 4, 1, 1, 0, 0));
        tbl.push_back(mk(0, 4'd0,  1, 0, 16'h1230, 4, 0, 1, 0, 0)); // acknowledged -> RUN
        tbl.push_back(mk(1, 4'd5,  0, 0, 16'h1230, 4, 0, 1, 0, 0));
        tbl.push_back(mk(1, 4'd11, 0, 0, 16'h1230, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'd0,  1, 0, 16'h1230, 4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'd0,  1, 1, 16'h0000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'd0,  0, 0, 16'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd5,  0, 0, 16'h0005, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd9,  0, 0, 16'h0059, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd7,  0, 0, 16'h0597, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd1,  0, 0, 16'h5971, 4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd4,  0, 0, 16'h5971, 4, 0, 0, 0, 0)); // fifth digit discarded
        tbl.push_back(mk(1, 4'd11, 0, 0, 16'h5971, 4, 0, 0, 1, 0)); // seconds tens 7 rejected
        tbl.push_back(mk(0, 4'd0,  0, 0, 16'h5971, 4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd10, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd11, 0, 0, 16'h0000, 0, 0, 0, 0, 0)); // START with no digits
        tbl.push_back(mk(1, 4'd0,  0, 0, 16'h0000, 1, 0, 0, 0, 0)); // leading zero counts
        tbl.push_back(mk(1, 4'd11, 0, 0, 16'h0000, 1, 0, 0, 0, 0)); // all zero -> ignored
        tbl.push_back(mk(1, 4'd4,  0, 0, 16'h0004, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd13, 0, 0, 16'h0004, 2, 0, 0, 0, 0)); // code 13 ignored
        tbl.push_back(mk(1, 4'd10, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd6,  0, 0, 16'h0006, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'd11, 0, 0, 16'h0006, 1, 1, 1, 0, 0)); // 6 s is legal

        do_reset();
        check("reset_outputs", 32'(dut_out()), 32'd0);

        foreach (tbl[i]) begin
            cycle(tbl[i].kv, tbl[i].kc, tbl[i].tk, tbl[i].tz);
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'({tbl[i].dig, tbl[i].cnt, tbl[i].ld, tbl[i].cl, tbl[i].bz, tbl[i].er, tbl[i].dn}));
        end

        // Load 0002, two non-zero ticks, then finish: exactly one done pulse.
        begin
            int done_seen;
            do_reset();
            cycle(1, 4'd0, 0, 0); cycle(1, 4'd0, 0, 0);
            cycle(1, 4'd0, 0, 0); cycle(1, 4'd2, 0, 0);
            check("load0002_digits", 32'({bus.second_min, bus.first_min, bus.second_sec, bus.first_sec}), 32'h0002);
            cycle(1, 4'd11, 0, 0);
            idle(1);
            cycle(0, 4'd0, 1, 0);
            check("load0002_run", 32'({bus.load_time_en, bus.busy}), 32'b01);
            done_seen = 0;
            cycle(0, 4'd0, 1, 0); done_seen += int'(bus.done);
            idle(2);
            cycle(0, 4'd0, 1, 0); done_seen += int'(bus.done);
            check("cook_no_early_done", 32'(done_seen), 32'd0);
            cycle(0, 4'd0, 1, 1);
            check("cook_done_pulse", 32'({bus.done, bus.busy}), 32'b10);
            check("cook_digits_cleared", 32'({bus.second_min, bus.first_min, bus.second_sec, bus.first_sec, bus.digit_count}), 32'd0);
            idle(1);
            check("cook_done_one_cycle", 32'(bus.done), 32'd0);
        end

        // CLEAR colliding with tick && timer_zero in RUN: CLEAR wins.
        do_reset();
        cycle(1, 4'd7, 0, 0);
        cycle(1, 4'd11, 0, 0);
        idle(1);
        cycle(0, 4'd0, 1, 0);
        cycle(1, 4'd10, 1, 1);
        check("clr_collide", 32'({bus.clear_input, bus.done, bus.load_time_en, bus.busy}), 32'b1001);
        idle(3);
        check("clr_held", 32'({bus.clear_input, bus.busy, bus.first_sec}), 32'({2'b11, 4'd7}));
        cycle(0, 4'd0, 1, 1);
        check("clr_release", 32'(dut_out()), 32'd0);

        // Asynchronous reset while a load request is pending.
        do_reset();
        cycle(1, 4'd3, 0, 0);
        cycle(1, 4'd11, 0, 0);
        check("rst_pre_load", 32'(bus.load_time_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_load", 32'(dut_out()), 32'd0);
        #2 reset_n = 1'b1;
        model_reset();
        cycle(1, 4'd8, 0, 0);
        check("rst_then_key8", 32'({bus.first_sec, bus.digit_count}), 32'({4'd8, 3'd1}));

        // Random keys and ticks against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       kv, tk, tz;
            logic [3:0] kc;
            kv = ($urandom_range(0, 2) == 0);
            kc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) kc = 4'd11;
            tk = ($urandom_range(0, 5) == 0);
            tz = ($urandom_range(0, 2) == 0);
            cycle(kv, kc, tk, tz);
            check("rand", 32'(dut_out()), 32'(model_out()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/time_entry.md
Name: time_entry

Overview:
- Keypad-side writer for the countdown timer. Collects up to four BCD digits microwave-style (shift-in from the right), validates them, and drives the timer's initial-digit, load and clear inputs.
- The timer samples on its slow 1 s clock edge, so every load or clear request is held until a `tick_1s` strobe confirms the timer has sampled it.
- Sits between the keypad decoder and the timer on the fast system clock.

Parameters:
- MAX_DIGITS, 4, number of digits accepted before further digits are discarded (1..4).
- MAX_SEC_TENS, 5, largest legal seconds-tens digit; a higher value rejects START.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  4  0-9 digit, 10 CLEAR, 11 START, 12-15 ignored.
- tick_1s  in  1  one-cycle pulse in the clk domain coincident with the timer's clk_1s rising edge.
- timer_zero  in  1  high when all four timer current digits are 0.
- first_sec  out  4  seconds units to timer.
- second_sec  out  4  seconds tens to timer.
- first_min  out  4  minutes units to timer.
- second_min  out  4  minutes tens to timer.
- load_time_en  out  1  load request to timer, held until acknowledged.
- clear_input  out  1  clear request to timer, held until acknowledged.
- digit_count  out  3  digits entered so far, 0..MAX_DIGITS.
- busy  out  1  high in LOAD, RUN, CLR.
- entry_error  out  1  one-cycle pulse when START is rejected.
- done  out  1  one-cycle pulse when a cook completes normally.

Behaviour:
- Reset, asynchronous on reset_n low:
  - State IDLE.
  - All four digits, digit_count, load_time_en, clear_input, busy, entry_error and done are 0.
  - Reset mid-LOAD or mid-CLR drops the request immediately.
- States: IDLE, ENTRY, LOAD, RUN, CLR. All outputs are registered. Keys are acted on only in the cycle where key_valid is high.
- IDLE/ENTRY, digit key d:
  - If digit_count < MAX_DIGITS: second_min <= first_min, first_min <= second_sec, second_sec <= first_sec, first_sec <= d, and digit_count increments.
  - If digit_count = MAX_DIGITS: the key is discarded and nothing changes.
  - A leading 0 counts as a digit.
  - State becomes ENTRY.
- IDLE/ENTRY, CLEAR: digits and digit_count go to 0, state IDLE. clear_input is not asserted because the timer is idle.
- IDLE/ENTRY, START:
  - If all digits are 0, the key is ignored.
  - Else if second_sec > MAX_SEC_TENS: entry_error pulses for 1 cycle, digits are kept, state unchanged.
  - Else: load_time_en goes high next cycle, state LOAD.
- LOAD:
  - load_time_en and the digit outputs are held stable; all keys are ignored.
  - On the first cycle with tick_1s high: next cycle load_time_en = 0, state RUN.
  - tick_1s in the same cycle as the entry to LOAD does not count; the request must be visible for one full cycle before the tick.
- RUN:
  - Digit outputs are frozen; digit and START keys are ignored.
  - tick_1s && timer_zero: done pulses 1 cycle, digits and digit_count clear, state IDLE.
  - CLEAR key: clear_input goes high, state CLR. If CLEAR arrives in the same cycle as tick_1s && timer_zero, CLEAR wins and done is not pulsed.
- CLR:
  - clear_input is held and keys are ignored.
  - On the first tick_1s: next cycle clear_input = 0, digits and digit_count go to 0, state IDLE.
- busy is 1 exactly in LOAD, RUN, CLR.
- load_time_en and clear_input are never high together.
- Digit outputs are always valid BCD (0-9). digit_count never exceeds MAX_DIGITS.

Test Plan:
- Keys 1,2,3,0 then START, tick_1s after 5 cycles: digits show second_min=1, first_min=2, second_sec=3, first_sec=0. load_time_en is high from the cycle after START until the cycle after the tick, then busy=1 and the block is in RUN.
- Keys 5,9,7,1,4: only 5,9,7,1 are taken, digit_count=4. Then START: entry_error pulses once (second_sec=7 > 5), load_time_en stays 0, digits unchanged.
- START with no digits: no entry_error, no load_time_en, state stays IDLE. Then keys 4,CLEAR: digits 0000, digit_count=0.
- Load 0002, then drive timer_zero=0 for 2 ticks and 1 on the next tick: done pulses exactly once at that tick, busy falls, digits read 0000.
- In RUN, press CLEAR in the same cycle as tick_1s with timer_zero=1: clear_input rises, done stays 0. It is held until the next tick_1s, then drops and the block returns to IDLE.
- Assert reset_n low while in LOAD: load_time_en drops asynchronously, all outputs 0. After release, a key 8 gives first_sec=8, digit_count=1.
